// File: rtl/seven_seg_reader_if.sv
// Two-digit seven-segment display bus as seen by the reader: raw segment inputs plus decoded results.
// The master drives segments and observes results; the reader uses the slave side.
interface seven_seg_reader_if;
  logic [6:0] seg_one;
  logic [6:0] seg_ten;
  logic [3:0] one_bcd;
  logic [3:0] ten_bcd;
  logic [6:0] value;
  logic       valid;
  logic       update;
  logic       wrap;
  logic       step_err;
  logic       err_invalid;

  modport master (
    output seg_one, seg_ten,
    input  one_bcd, ten_bcd, value, valid, update, wrap, step_err, err_invalid
  );

  modport slave (
    input  seg_one, seg_ten,
    output one_bcd, ten_bcd, value, valid, update, wrap, step_err, err_invalid
  );
endinterface

// File: rtl/seven_seg_reader.sv
// Debounces a two-digit seven-segment bus, decodes it to BCD/binary and checks the +1 mod 100 count.
// Latency STABLE_CYCLES+1 edges from first sample to outputs; no backpressure, the display is sampled every edge.
module seven_seg_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input logic              clkin,
  input logic              rst,
  seven_seg_reader_if.slave bus
);

  localparam logic [7:0] LP_LAST = 8'(STABLE_CYCLES - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  // Returns {legal, digit}; blank and any non-digit pattern decode as illegal.
  function automatic logic [4:0] f_decode(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'h7E:   res = 5'h10;
      7'h30:   res = 5'h11;
      7'h6D:   res = 5'h12;
      7'h79:   res = 5'h13;
      7'h33:   res = 5'h14;
      7'h5B:   res = 5'h15;
      7'h5F:   res = 5'h16;
      7'h70:   res = 5'h17;
      7'h7F:   res = 5'h18;
      7'h7B:   res = 5'h19;
      default: res = 5'h00;
    endcase
    return res;
  endfunction

  logic [13:0] r_samp;
  logic [7:0]  r_stcnt;
  logic [13:0] r_comm;
  logic        r_comm_vld;
  state_t      r_state;

  logic [3:0]  r_one;
  logic [3:0]  r_ten;
  logic [6:0]  r_value;
  logic        r_valid;
  logic        r_update;
  logic        r_wrap;
  logic        r_step_err;
  logic        r_err_inv;

  logic [13:0] w_new;
  logic [4:0]  w_one_dec;
  logic [4:0]  w_ten_dec;
  logic        w_legal;
  logic        w_commit;
  logic [6:0]  w_val_new;
  logic [6:0]  w_val_exp;
  state_t      w_state_nxt;

  logic [3:0]  w_one_nxt;
  logic [3:0]  w_ten_nxt;
  logic [6:0]  w_value_nxt;
  logic        w_valid_nxt;
  logic        w_update_nxt;
  logic        w_wrap_nxt;
  logic        w_step_err_nxt;
  logic        w_err_inv_nxt;

  assign w_new     = {bus.seg_ten, bus.seg_one};
  assign w_one_dec = f_decode(r_samp[6:0]);
  assign w_ten_dec = f_decode(r_samp[13:7]);
  assign w_legal   = w_one_dec[4] & w_ten_dec[4];

  // Re-stabilising on the pattern already committed (e.g. after a short glitch) must not commit again.
  assign w_commit  = (r_stcnt == LP_LAST) && (!r_comm_vld || (r_samp != r_comm));

  // tens*10 = tens*8 + tens*2, kept in 7 bits
  assign w_val_new = ({3'b000, w_ten_dec[3:0]} << 3) + ({3'b000, w_ten_dec[3:0]} << 1)
                   + {3'b000, w_one_dec[3:0]};
  assign w_val_exp = (r_value == 7'd99) ? 7'd0 : (r_value + 7'd1);

  // Sample register, stability counter and committed-pattern memory
  always_ff @(posedge clkin) begin
    if (rst) begin
      r_samp     <= '0;
      r_stcnt    <= '0;
      r_comm     <= '0;
      r_comm_vld <= 1'b0;
    end else begin
      r_samp <= w_new;
      if (w_new != r_samp) begin
        r_stcnt <= '0;
      end else if (r_stcnt != LP_LAST) begin
        r_stcnt <= r_stcnt + 8'd1;
      end
      if (w_commit) begin
        r_comm     <= r_samp;
        r_comm_vld <= 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clkin) begin
    if (rst) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: only a legal commit leaves INIT; nothing returns to INIT except reset
  always_comb begin
    w_state_nxt = r_state;
    if (w_commit && w_legal) begin
      w_state_nxt = ST_RUN;
    end
  end

  // FSM outputs
  always_comb begin
    w_one_nxt      = r_one;
    w_ten_nxt      = r_ten;
    w_value_nxt    = r_value;
    w_valid_nxt    = r_valid;
    w_update_nxt   = 1'b0;
    w_wrap_nxt     = 1'b0;
    w_step_err_nxt = r_step_err;
    w_err_inv_nxt  = r_err_inv;
    if (w_commit) begin
      if (w_legal) begin
        w_one_nxt    = w_one_dec[3:0];
        w_ten_nxt    = w_ten_dec[3:0];
        w_value_nxt  = w_val_new;
        w_valid_nxt  = 1'b1;
        w_update_nxt = 1'b1;
        if (r_state == ST_RUN) begin
          if (w_val_new != w_val_exp) begin
            w_step_err_nxt = 1'b1;
          end
          if ((r_value == 7'd99) && (w_val_new == 7'd0)) begin
            w_wrap_nxt = 1'b1;
          end
        end
      end else begin
        w_err_inv_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      r_one      <= '0;
      r_ten      <= '0;
      r_value    <= '0;
      r_valid    <= 1'b0;
      r_update   <= 1'b0;
      r_wrap     <= 1'b0;
      r_step_err <= 1'b0;
      r_err_inv  <= 1'b0;
    end else begin
      r_one      <= w_one_nxt;
      r_ten      <= w_ten_nxt;
      r_value    <= w_value_nxt;
      r_valid    <= w_valid_nxt;
      r_update   <= w_update_nxt;
      r_wrap     <= w_wrap_nxt;
      r_step_err <= w_step_err_nxt;
      r_err_inv  <= w_err_inv_nxt;
    end
  end

  assign bus.one_bcd     = r_one;
  assign bus.ten_bcd     = r_ten;
  assign bus.value       = r_value;
  assign bus.valid       = r_valid;
  assign bus.update      = r_update;
  assign bus.wrap        = r_wrap;
  assign bus.step_err    = r_step_err;
  assign bus.err_invalid = r_err_inv;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Bench for seven_seg_reader: directed display patterns, expected commits queued and checked by a monitor.
module tb_seven_seg_reader;

  typedef struct {
    int value;
    bit wrap;
    bit step;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   n_upd;
  int   n_wrap;
  int   n_push;
  exp_t q[$];
  logic [6:0] seg_tab [10];

  seven_seg_reader_if bus ();

  seven_seg_reader #(.STABLE_CYCLES(4)) dut (
    .clkin (clk),
    .rst   (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_dig(input int t, input int o);
    bus.seg_ten = seg_tab[t];
    bus.seg_one = seg_tab[o];
  endtask

  task automatic push_exp(input int v, input bit w, input bit s);
    exp_t e;
    e.value = v;
    e.wrap  = w;
    e.step  = s;
    q.push_back(e);
    n_push++;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_value"},  int'(bus.value), 0);
    chk({nm, "_one"},    int'(bus.one_bcd), 0);
    chk({nm, "_ten"},    int'(bus.ten_bcd), 0);
    chk({nm, "_valid"},  int'(bus.valid), 0);
    chk({nm, "_update"}, int'(bus.update), 0);
    chk({nm, "_wrap"},   int'(bus.wrap), 0);
    chk({nm, "_steperr"}, int'(bus.step_err), 0);
    chk({nm, "_errinv"}, int'(bus.err_invalid), 0);
  endtask

  // Monitor: every update pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (bus.wrap && !bus.update) begin
      chk("wrap_without_update", 1, 0);
    end
    if (bus.update) begin
      n_upd++;
      if (bus.wrap) n_wrap++;
      if (q.size() == 0) begin
        chk("unexpected_update_value", int'(bus.value), -1);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("upd_value", int'(bus.value), e.value);
        chk("upd_one",   int'(bus.one_bcd), e.value % 10);
        chk("upd_ten",   int'(bus.ten_bcd), e.value / 10);
        chk("upd_valid", int'(bus.valid), 1);
        chk("upd_wrap",  int'(bus.wrap), int'(e.wrap));
        chk("upd_step",  int'(bus.step_err), int'(e.step));
      end
    end
  end

  initial begin
    int lat;
    checks = 0;
    errors = 0;
    n_upd  = 0;
    n_wrap = 0;
    n_push = 0;
    seg_tab[0] = 7'h7E; seg_tab[1] = 7'h30; seg_tab[2] = 7'h6D; seg_tab[3] = 7'h79;
    seg_tab[4] = 7'h33; seg_tab[5] = 7'h5B; seg_tab[6] = 7'h5F; seg_tab[7] = 7'h70;
    seg_tab[8] = 7'h7F; seg_tab[9] = 7'h7B;

    rst = 1'b1;
    set_dig(0, 0);
    cyc(3);
    chk_zero("reset");

    // First commit of 00: update on the 5th edge after release
    push_exp(0, 1'b0, 1'b0);
    rst = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.update) begin
        lat = i;
        break;
      end
    end
    chk("first_commit_latency", lat, 5);
    chk("first_step_err", int'(bus.step_err), 0);
    cyc(5);

    // Full sweep 01..99 then back to 00
    for (int v = 1; v <= 99; v++) begin
      push_exp(v, 1'b0, 1'b0);
      set_dig(v / 10, v % 10);
      cyc(10);
    end
    push_exp(0, 1'b1, 1'b0);
    set_dig(0, 0);
    cyc(10);
    chk("sweep_updates", n_upd, 101);
    chk("sweep_wraps", n_wrap, 1);
    chk("sweep_step_err", int'(bus.step_err), 0);
    chk("sweep_err_inv", int'(bus.err_invalid), 0);

    // Count up to 05, then a 3-sample glitch of 06
    for (int v = 1; v <= 5; v++) begin
      push_exp(v, 1'b0, 1'b0);
      set_dig(0, v);
      cyc(10);
    end
    set_dig(0, 6);
    cyc(3);
    set_dig(0, 5);
    cyc(10);
    chk("glitch_value", int'(bus.value), 5);
    chk("glitch_updates", n_upd, 106);

    // Skip to 07 raises step_err, which stays set through 08
    push_exp(7, 1'b0, 1'b1);
    set_dig(0, 7);
    cyc(10);
    push_exp(8, 1'b0, 1'b1);
    set_dig(0, 8);
    cyc(10);
    chk("sticky_step_err", int'(bus.step_err), 1);

    // Blank ones digit is illegal
    bus.seg_ten = 7'h7E;
    bus.seg_one = 7'h00;
    cyc(10);
    chk("blank_err_inv", int'(bus.err_invalid), 1);
    chk("blank_value", int'(bus.value), 8);
    chk("blank_valid", int'(bus.valid), 1);

    push_exp(12, 1'b0, 1'b1);
    set_dig(1, 2);
    cyc(10);
    bus.seg_ten = 7'h30;
    bus.seg_one = 7'h4A;
    cyc(10);
    chk("bad4a_value", int'(bus.value), 12);
    chk("bad4a_err_inv", int'(bus.err_invalid), 1);

    // Reset mid-settle while 40 is committed
    push_exp(40, 1'b0, 1'b1);
    set_dig(4, 0);
    cyc(10);
    chk("pre_reset_value", int'(bus.value), 40);
    set_dig(1, 7);
    cyc(3);
    rst = 1'b1;
    cyc(1);
    chk_zero("midreset");
    push_exp(17, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(10);
    chk("post_reset_value", int'(bus.value), 17);
    chk("post_reset_step_err", int'(bus.step_err), 0);
    chk("post_reset_err_inv", int'(bus.err_invalid), 0);

    chk("queue_drained", q.size(), 0);
    chk("total_updates", n_upd, n_push);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_reader.md
Name: seven_seg_reader

Overview:
- Receive-side monitor for the two-digit seven-segment display bus driven by the team's counter/display blocks.
- Takes the two raw 7-bit segment patterns (ones and tens), filters glitches by requiring a stable pattern, and decodes it back to BCD digits and a binary value 0..99.
- Checks that successive committed values follow the +1 mod 100 count sequence.
- Used as an on-board self-checker and as the bench-side scoreboard for display-driving modules.

Parameters:
- STABLE_CYCLES, 4: number of consecutive identical samples required before a pattern is committed. Legal range is 1..255.

Ports:
- clkin  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- seg_one  input  7  ones-digit segment pattern. Bit 6 = a ... bit 0 = g; 1 = segment lit.
- seg_ten  input  7  tens-digit segment pattern, same encoding.
- one_bcd  output  4  last committed ones digit.
- ten_bcd  output  4  last committed tens digit.
- value  output  7  last committed value, equal to ten_bcd*10 + one_bcd.
- valid  output  1  set once at least one legal pattern has been committed since reset.
- update  output  1  one-cycle pulse on each commit of a new legal value.
- wrap  output  1  one-cycle pulse, coincident with update, when the value steps from 99 to 0.
- step_err  output  1  sticky flag: a committed value was not the previous value +1 mod 100.
- err_invalid  output  1  sticky flag: a stable pattern contained an undecodable digit.

Behaviour:
- Reset (rst=1 at an edge): all outputs go to 0, the FSM enters INIT, the sample register and stable counter clear, and the committed-pattern register is marked empty. Reset has priority over everything, including a commit on the same edge.
- Legal digit patterns (hex):
  - 0=7E, 1=30, 2=6D, 3=79, 4=33
  - 5=5B, 6=5F, 7=70, 8=7F, 9=7B
  - Any other code, including 00 (blank), is invalid.
- Sampling:
  - {seg_ten,seg_one} is registered every edge into samp.
  - If the new sample differs from samp, stcnt is set to 0.
  - If it is equal, stcnt increments, saturating at STABLE_CYCLES-1.
- Commit condition: stcnt == STABLE_CYCLES-1, and samp differs from the committed pattern (or the committed pattern is empty).
  - A pattern must be sampled identically at STABLE_CYCLES consecutive edges E0..E0+S-1. Outputs change at edge E0+S, so latency is S+1 edges from the first edge that sampled it.
  - With S=1, each pattern change commits on the following edge.
- On commit, samp is stored as the committed pattern in every case. Then:
  - Both digits legal: one_bcd, ten_bcd and value load the decoded values; valid=1; update=1 for one cycle.
  - Step check applies if the FSM was in RUN: new value != (old value + 1) mod 100 sets step_err. If old=99 and new=0, wrap=1 with update.
  - Either digit illegal: err_invalid is set. value, bcd outputs and valid are unchanged, and there is no update or wrap pulse.
- Re-stability of the already-committed pattern (e.g. returning after a short glitch) causes no action.
- FSM states:
  - INIT: no legal commit yet. A legal commit goes to RUN with no step check; an illegal commit stays in INIT.
  - RUN: a legal commit stays in RUN with the step check; an illegal commit stays in RUN, outputs held.
- Glitches lasting fewer than STABLE_CYCLES samples are ignored and do not reset the committed value.
- Sticky flags clear only on rst.
- Arithmetic: value is computed via a 4-bit x 10 add in 7 bits; the +1 mod 100 compare is done in 7 bits with explicit 99->0 handling.
- update and wrap are never asserted during or on the edge of reset.

Test Plan:
- Reset, then hold seg_ten=7E, seg_one=7E (S=4) -> no update for the first 4 sampling edges; at the 5th edge update=1, value=0, valid=1, step_err=0.
- Sweep 00..99..00, each pattern held 10 cycles -> 101 update pulses; value tracks 0..99,0; wrap=1 exactly once, at 99->0; step_err=0, err_invalid=0.
- Hold 05 (7E,5B), inject 06 (5F) for 3 cycles, then 05 again -> no update; value stays 5.
- Committed 05, then stable 07 -> value=7, update=1, step_err=1; step_err is still 1 after a following legal 08.
- Hold seg_one=00 with seg_ten=7E -> err_invalid=1, no update, value and valid unchanged. Set up 12, then hold 4A on seg_one -> value stays 12.
- Assert rst mid-settle (stcnt=2) while value=40 -> all outputs 0, valid=0. Then a stable 17 commits with value=17 and no step_err, because the FSM is in INIT.
